// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the successive-approximation search
// controller.
//   state_e            FSM state encoding {IDLE, TRY, EVAL, DONE}
//   SAR_WIDTH_DEFAULT  default operand width
//   one_hot3()         comparator flag validity (exactly one flag high)
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int SAR_WIDTH_DEFAULT = 4;

    // The comparator must report exactly one relation per compare.
    function automatic logic one_hot3(input logic e, input logic g, input logic l);
        logic ok;
        case ({e, g, l})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sar_search_ctrl_flag_decode.sv
// sar_flag_decode: combinational decode of the comparator flags.
// Ports:
//   a_e_b_i, a_g_b_i, a_l_b_i  comparator flags (A==B, A>B, A<B)
//   keep_bit_o                 trial bit belongs in the result (A >= Trial)
//   equal_o                    A == Trial
//   flag_error_o               flags are not one-hot
module sar_flag_decode
    import sar_pkg::*;
(
    input  logic a_e_b_i,
    input  logic a_g_b_i,
    input  logic a_l_b_i,
    output logic keep_bit_o,
    output logic equal_o,
    output logic flag_error_o
);

    assign keep_bit_o   = a_g_b_i | a_e_b_i;
    assign equal_o      = a_e_b_i;
    assign flag_error_o = ~one_hot3(a_e_b_i, a_g_b_i, a_l_b_i);

endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: successive-approximation search controller. Drives the B
// operand (Trial) of an unsigned magnitude comparator and recovers the value
// on its A operand, MSB first, followed by one verify compare.
//
// Build option: define SAR_EARLY_EXIT_EN to finish as soon as a bit-phase
// compare reports equality (remaining bits and the verify compare skipped).
//
// Handshake: Start is sampled only in IDLE; a pulse while Busy is dropped.
// Busy rises on the accepting edge and falls when DONE is left; Done is a
// one-cycle pulse, and Result/Found/Error are valid with it and hold until
// the next accepted Start.
//
// Ports:
//   Clk, Reset_n            clock, synchronous active-low reset
//   Start                   request a new search
//   A_E_B, A_G_B, A_L_B     comparator flags for A vs Trial
//   Trial                   candidate driven to comparator B
//   Result                  recovered value
//   Busy, Done              search in progress / finished pulse
//   Found, Error            equality confirmed / flag protocol violation
//   Dbg_State               current FSM state (debug)
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             A_E_B,
    input  logic             A_G_B,
    input  logic             A_L_B,
    output logic [WIDTH-1:0] Trial,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done,
    output logic             Found,
    output logic             Error,
    output logic [1:0]       Dbg_State
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_MSB   = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TRIAL_MSB = WIDTH'(1) << (WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] trial_q, result_q;
    logic [IW-1:0]    idx_q;
    logic             busy_q, done_q, found_q, error_q, verify_q;

    logic             keep_bit, equal, flag_error;
    logic [WIDTH-1:0] result_d, trial_bit_d;
    logic [IW-1:0]    idx_d;

    sar_flag_decode u_flag_decode (
        .a_e_b_i     (A_E_B),
        .a_g_b_i     (A_G_B),
        .a_l_b_i     (A_L_B),
        .keep_bit_o  (keep_bit),
        .equal_o     (equal),
        .flag_error_o(flag_error)
    );

    // Result with the current bit decided, and the next bit to try.
    always_comb begin
        result_d = result_q;
        if (keep_bit) result_d[idx_q] = 1'b1;
        idx_d = idx_q - IW'(1);
        trial_bit_d = '0;
        trial_bit_d[idx_d] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= IDX_MSB;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
            verify_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        result_q <= '0;
                        found_q  <= 1'b0;
                        error_q  <= 1'b0;
                        verify_q <= 1'b0;
                        idx_q    <= IDX_MSB;
                        trial_q  <= TRIAL_MSB;
                        busy_q   <= 1'b1;
                        state_q  <= TRY;
                    end
                end
                TRY: state_q <= EVAL;
                EVAL: begin
                    if (flag_error) begin
                        // Partial result is kept for diagnosis.
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (verify_q) begin
                        found_q <= equal;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        result_q <= result_d;
`ifdef SAR_EARLY_EXIT_EN
                        if (equal) begin
                            found_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else
`endif
                        if (idx_q != '0) begin
                            idx_q   <= idx_d;
                            trial_q <= result_d | trial_bit_d;
                            state_q <= TRY;
                        end else begin
                            verify_q <= 1'b1;
                            trial_q  <= result_d;
                            state_q  <= TRY;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Trial     = trial_q;
    assign Result    = result_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Found     = found_q;
    assign Error     = error_q;
    assign Dbg_State = state_q;

endmodule
